// File: rtl/addr_cmd_gen.sv
// Counted, back-pressure-aware address/command burst generator (sequential, stride, LFSR, fixed).
// Optional per-direction transfer counters (wr_cnt/rd_cnt) enabled by defining ADDR_CMD_GEN_STATS_EN.
module addr_cmd_gen #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        cfg_mode,
    input  logic [1:0]        cfg_wr_mode,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_stride,
    input  logic [CNT_W-1:0]  cfg_count,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic              cmd_wr,
    output logic              busy,
    output logic              done,
`ifdef ADDR_CMD_GEN_STATS_EN
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
`endif
    output logic [CNT_W-1:0]  txn_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [1:0] {M_SEQ, M_STRIDE, M_LFSR, M_FIXED} addr_mode_t;
    typedef enum logic [1:0] {W_READ, W_WRITE, W_ALT, W_LFSR} wr_mode_t;

    state_t            r_state;
    addr_mode_t        r_mode;
    wr_mode_t          r_wr_mode;
    logic [ADDR_W-1:0] r_stride;
    logic [CNT_W-1:0]  r_count;
    logic [15:0]       r_lfsr;
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_txn_cnt;
`ifdef ADDR_CMD_GEN_STATS_EN
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [CNT_W-1:0]  r_rd_cnt;
`endif

    logic              w_xfer;
    logic              w_last;
    logic              w_lfsr_adv;
    logic [15:0]       w_lfsr_next;
    logic [15:0]       w_lfsr_upd;
    logic [ADDR_W-1:0] w_addr_next;
    logic              w_wr_next;
    logic              w_wr_first;

    assign w_xfer      = r_valid & cmd_ready;
    assign w_last      = ((r_txn_cnt + CNT_W'(1)) == r_count);
    // Shared LFSR steps once per transfer if either the address or the write flag consumes it.
    assign w_lfsr_adv  = (r_mode == M_LFSR) || (r_wr_mode == W_LFSR);
    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_lfsr_upd  = w_lfsr_adv ? w_lfsr_next : r_lfsr;

    always_comb begin
        w_addr_next = r_addr;
        case (r_mode)
            M_SEQ:    w_addr_next = r_addr + ADDR_W'(1);
            M_STRIDE: w_addr_next = r_addr + r_stride;
            M_LFSR:   w_addr_next = w_lfsr_next[ADDR_W-1:0];
            M_FIXED:  w_addr_next = r_addr;
            default:  w_addr_next = r_addr;
        endcase
    end

    always_comb begin
        w_wr_next = 1'b0;
        case (r_wr_mode)
            W_READ:  w_wr_next = 1'b0;
            W_WRITE: w_wr_next = 1'b1;
            W_ALT:   w_wr_next = ~r_wr;
            W_LFSR:  w_wr_next = w_lfsr_next[15];
            default: w_wr_next = 1'b0;
        endcase
    end

    always_comb begin
        w_wr_first = 1'b0;
        case (wr_mode_t'(cfg_wr_mode))
            W_READ:  w_wr_first = 1'b0;
            W_WRITE: w_wr_first = 1'b1;
            W_ALT:   w_wr_first = 1'b1;
            W_LFSR:  w_wr_first = LFSR_SEED[15];
            default: w_wr_first = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mode    <= M_SEQ;
            r_wr_mode <= W_READ;
            r_stride  <= '0;
            r_count   <= '0;
            r_lfsr    <= LFSR_SEED;
            r_valid   <= 1'b0;
            r_addr    <= '0;
            r_wr      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_txn_cnt <= '0;
`ifdef ADDR_CMD_GEN_STATS_EN
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mode    <= addr_mode_t'(cfg_mode);
                        r_wr_mode <= wr_mode_t'(cfg_wr_mode);
                        r_stride  <= cfg_stride;
                        r_count   <= cfg_count;
                        r_lfsr    <= LFSR_SEED;
                        r_txn_cnt <= '0;
`ifdef ADDR_CMD_GEN_STATS_EN
                        r_wr_cnt  <= '0;
                        r_rd_cnt  <= '0;
`endif
                        if (cfg_count == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                            r_valid <= 1'b1;
                            r_addr  <= cfg_base;
                            r_wr    <= w_wr_first;
                        end
                    end
                end

                S_RUN: begin
                    if (w_xfer) begin
                        r_txn_cnt <= r_txn_cnt + CNT_W'(1);
`ifdef ADDR_CMD_GEN_STATS_EN
                        if (r_wr) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                        else      r_rd_cnt <= r_rd_cnt + CNT_W'(1);
`endif
                    end
                    // Abort ends the burst even mid-stall; a same-cycle transfer is still counted above.
                    if (abort || (w_xfer && w_last)) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_xfer) begin
                        r_addr <= w_addr_next;
                        r_wr   <= w_wr_next;
                        r_lfsr <= w_lfsr_upd;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_valid = r_valid;
    assign cmd_addr  = r_addr;
    assign cmd_wr    = r_wr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign txn_cnt   = r_txn_cnt;
`ifdef ADDR_CMD_GEN_STATS_EN
    assign wr_cnt    = r_wr_cnt;
    assign rd_cnt    = r_rd_cnt;
`endif

endmodule

// File: tb/tb_addr_cmd_gen.sv
// Scoreboard bench for addr_cmd_gen: directed bursts, expected commands queued, monitor compares transfers.
module tb_addr_cmd_gen;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned CNT_W  = 16;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [1:0]        cfg_mode = '0;
    logic [1:0]        cfg_wr_mode = '0;
    logic [ADDR_W-1:0] cfg_base = '0;
    logic [ADDR_W-1:0] cfg_stride = '0;
    logic [CNT_W-1:0]  cfg_count = '0;
    logic              cmd_valid;
    logic              cmd_ready = 1'b1;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_wr;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  txn_cnt;
`ifdef ADDR_CMD_GEN_STATS_EN
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  rd_cnt;
`endif

    addr_cmd_gen #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_mode(cfg_mode), .cfg_wr_mode(cfg_wr_mode), .cfg_base(cfg_base),
        .cfg_stride(cfg_stride), .cfg_count(cfg_count),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_wr(cmd_wr), .busy(busy), .done(done),
`ifdef ADDR_CMD_GEN_STATS_EN
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt),
`endif
        .txn_cnt(txn_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wr;
    } cmd_t;

    cmd_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_xfer = 0;
    int   last_xfer_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Monitor: a transfer happens at the next posedge when valid&&ready are seen at the negedge.
    always @(negedge clk) begin
        cmd_t e;
        if (rst_n && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd: got addr %0h wr %0b expected no command", cmd_addr, cmd_wr);
            end else begin
                e = exp_q.pop_front();
                chk("cmd_addr", 32'(cmd_addr), 32'(e.addr));
                chk("cmd_wr", 32'(cmd_wr), 32'(e.wr));
            end
            n_xfer++;
            last_xfer_cyc = cyc + 1;
        end
        if (rst_n) begin
            chk("busy_eq_valid", 32'(busy), 32'(cmd_valid));
`ifdef ADDR_CMD_GEN_STATS_EN
            chk("stats_sum", 32'(CNT_W'(wr_cnt + rd_cnt)), 32'(txn_cnt));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [1:0] mode, input logic [1:0] wrm,
                                 input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride,
                                 input int count);
        logic [15:0]       lf;
        logic [ADDR_W-1:0] a;
        logic              w;
        lf = SEED;
        a  = base;
        w  = (wrm == 2'd0) ? 1'b0 : (wrm == 2'd3) ? lf[15] : 1'b1;
        for (int i = 0; i < count; i++) begin
            exp_q.push_back('{addr: a, wr: w});
            if (mode == 2'd2 || wrm == 2'd3) lf = lfsr_step(lf);
            case (mode)
                2'd0:    a = a + 1'b1;
                2'd1:    a = a + stride;
                2'd2:    a = lf[ADDR_W-1:0];
                default: a = a;
            endcase
            case (wrm)
                2'd0:    w = 1'b0;
                2'd1:    w = 1'b1;
                2'd2:    w = ~w;
                default: w = lf[15];
            endcase
        end
    endtask

    task automatic run_burst(input string tag, input logic [1:0] mode, input logic [1:0] wrm,
                             input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride,
                             input int count, input int stall_at, input int stall_len,
                             input int abort_at, input logic abort_rdy);
        int                start_cyc, abort_cyc, stalled, exp_n;
        logic              seen, aborted;
        logic [ADDR_W-1:0] hold;
        $display("burst %s", tag);
        push_expected(mode, wrm, base, stride, count);
        n_xfer = 0; stalled = 0; seen = 1'b0; aborted = 1'b0; abort_cyc = 0; hold = '0;
        cfg_mode = mode; cfg_wr_mode = wrm; cfg_base = base; cfg_stride = stride;
        cfg_count = CNT_W'(count);
        cmd_ready = 1'b1;
        start = 1'b1;
        step();
        start_cyc = cyc;
        // Configuration changes after acceptance must not affect the burst.
        cfg_mode = ~mode; cfg_wr_mode = ~wrm; cfg_base = ~base; cfg_stride = ~stride;
        cfg_count = CNT_W'(count + 3);
        chk({tag, "_first_valid"}, 32'(cmd_valid), 32'(count != 0));
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = (k == 0);
            cmd_ready = 1'b1;
            abort = 1'b0;
            if (n_xfer == stall_at && stalled < stall_len) begin
                cmd_ready = 1'b0;
                if (stalled == 0) hold = cmd_addr;
                else chk({tag, "_stall_hold"}, 32'(cmd_addr), 32'(hold));
                stalled++;
            end
            if (abort_at >= 0 && n_xfer == abort_at && !aborted) begin
                abort = 1'b1;
                cmd_ready = abort_rdy;
                aborted = 1'b1;
                abort_cyc = cyc;
            end
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        cmd_ready = 1'b1;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        exp_n = aborted ? abort_at + int'(abort_rdy) : count;
        if (aborted)         chk({tag, "_done_cyc"}, 32'(cyc), 32'(abort_cyc + 1));
        else if (count == 0) chk({tag, "_done_cyc"}, 32'(cyc), 32'(start_cyc));
        else                 chk({tag, "_done_cyc"}, 32'(cyc), 32'(last_xfer_cyc));
        chk({tag, "_valid_low"}, 32'(cmd_valid), 32'd0);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        chk({tag, "_txn_cnt"}, 32'(txn_cnt), 32'(exp_n));
        chk({tag, "_n_xfer"}, 32'(n_xfer), 32'(exp_n));
        step();
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, "_txn_hold"}, 32'(txn_cnt), 32'(exp_n));
        if (aborted) exp_q.delete();
        else chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        step();
    endtask

    initial begin
        int guard;
        #1;
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_addr", 32'(cmd_addr), 32'd0);
        chk("rst_wr", 32'(cmd_wr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_txn", 32'(txn_cnt), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 32'd0);
        chk("idle_abort_done", 32'(done), 32'd0);

        run_burst("seq",    2'd0, 2'd1, 6'h3E, 6'h00, 4,  -1, 0, -1, 1'b0);
        run_burst("stride", 2'd1, 2'd0, 6'h00, 6'h05, 3,   1, 3, -1, 1'b0);
        run_burst("lfsr_a", 2'd2, 2'd3, 6'h11, 6'h00, 8,  -1, 0, -1, 1'b0);
        run_burst("lfsr_b", 2'd2, 2'd3, 6'h11, 6'h00, 8,  -1, 0, -1, 1'b0);
        run_burst("alt",    2'd3, 2'd2, 6'h2A, 6'h00, 5,  -1, 0, -1, 1'b0);
        run_burst("wrrand", 2'd0, 2'd3, 6'h07, 6'h00, 6,   2, 2, -1, 1'b0);
        run_burst("zero",   2'd0, 2'd1, 6'h15, 6'h00, 0,  -1, 0, -1, 1'b0);
        run_burst("abort",  2'd0, 2'd0, 6'h20, 6'h00, 10, -1, 0,  2, 1'b0);
        run_burst("abortx", 2'd1, 2'd1, 6'h01, 6'h02, 10, -1, 0,  1, 1'b1);

        // Reset in the middle of a burst.
        $display("burst reset_mid");
        push_expected(2'd0, 2'd0, 6'h10, 6'h00, 10);
        n_xfer = 0;
        cfg_mode = 2'd0; cfg_wr_mode = 2'd0; cfg_base = 6'h10; cfg_count = 16'd10;
        start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (n_xfer < 3 && guard < 50) begin
            step();
            guard++;
        end
        chk("rstmid_reached", 32'(n_xfer), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", 32'(cmd_valid), 32'd0);
        chk("rstmid_addr", 32'(cmd_addr), 32'd0);
        chk("rstmid_wr", 32'(cmd_wr), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_done", 32'(done), 32'd0);
        chk("rstmid_txn", 32'(txn_cnt), 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rstmid_no_done", 32'(done), 32'd0);
        end
        run_burst("fresh",  2'd0, 2'd2, 6'h3C, 6'h00, 7,  -1, 0, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/addr_cmd_gen.md
Name: addr_cmd_gen

Overview:
Parametrised address/command generator. It produces a programmable burst of address + read/write commands on a valid/ready interface, in sequential, strided, LFSR-random or fixed address modes. It drives memory/peripheral stimulus paths and replaces free-running per-cycle random addr/en/wr generation with a counted, back-pressure-aware sequence.

Parameters:
ADDR_W, 6, address width in bits; legal range 1..16
CNT_W, 16, width of the transaction count and counter
LFSR_SEED, 16'hACE1, reset and restart seed of the 16-bit LFSR; must be non-zero

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  level-sampled in IDLE; begins a burst
abort  in  1  terminates the active burst
cfg_mode  in  2  0=sequential, 1=stride, 2=LFSR random, 3=fixed
cfg_wr_mode  in  2  0=all reads, 1=all writes, 2=alternate (first is write), 3=LFSR random
cfg_base  in  ADDR_W  first address
cfg_stride  in  ADDR_W  increment for mode 1
cfg_count  in  CNT_W  number of commands in the burst
cmd_valid  out  1  command present; acts as en
cmd_ready  in  1  consumer accepts when high with cmd_valid
cmd_addr  out  ADDR_W  command address
cmd_wr  out  1  1=write, 0=read
busy  out  1  high in RUN
done  out  1  one-cycle pulse at burst end
txn_cnt  out  CNT_W  commands accepted in the current or last burst

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, cmd_valid=0, cmd_addr=0, cmd_wr=0, busy=0, done=0, txn_cnt=0, LFSR=LFSR_SEED.
- FSM states are IDLE, RUN and DONE.
- IDLE -> RUN when start=1. All cfg_* inputs are captured that cycle, txn_cnt clears to 0, and the LFSR reloads LFSR_SEED.
- If the captured count is 0, the FSM goes IDLE -> DONE instead. No command is issued.
- Latency: the first command appears one cycle after start is sampled, with cmd_valid=1 and cmd_addr=cfg_base.
- First cmd_wr by wr_mode: 0 -> 0; 1 -> 1; 2 -> 1; 3 -> LFSR bit 15.
- Handshake: a transfer occurs when cmd_valid && cmd_ready. While cmd_valid=1 && cmd_ready=0, cmd_addr and cmd_wr hold stable. cmd_valid never drops without a transfer, except on abort or reset.
- On each transfer, txn_cnt increments and the next command is loaded the same edge, so there are no bubbles and back-to-back ready gives 1 command/cycle.
- Next-address rules (all wrap modulo 2^ADDR_W, no error flagged):
  - Mode 0: addr+1.
  - Mode 1: addr+stride.
  - Mode 2: the LFSR advances one step and addr = new LFSR[ADDR_W-1:0]. Polynomial is x^16+x^14+x^13+x^11+1, Fibonacci form, shifting left with feedback into bit 0.
  - Mode 3: addr unchanged.
- Next-wr rules: mode 2 toggles. Mode 3 takes bit 15 of the LFSR, which advances on each transfer in wr_mode 3 even if the addr mode is not 2. The LFSR advances at most once per transfer.
- When the transfer that makes txn_cnt == captured count occurs: RUN -> DONE, and cmd_valid=0 on the next cycle.
- DONE lasts exactly one cycle with done=1, then goes to IDLE. txn_cnt holds its final value until the next start.
- Abort in RUN takes priority over a simultaneous transfer for the state change, but a transfer in that same cycle still counts. Next cycle: cmd_valid=0, state DONE, done pulse. Abort in IDLE or DONE has no effect.
- start while in RUN or DONE is ignored. Changes to cfg_* during RUN have no effect.
- busy=1 exactly while state==RUN.
- Reset mid-burst returns all outputs to reset values immediately (asynchronously). No done pulse.

Optional Feature:
Macro ADDR_CMD_GEN_STATS_EN.
- Defined: adds outputs wr_cnt and rd_cnt, CNT_W each, both reset to 0. They clear on start accepted in IDLE and increment on each transfer with cmd_wr=1 or cmd_wr=0 respectively. Invariant: wr_cnt+rd_cnt==txn_cnt.
- Undefined: these ports and their counters do not exist. All other behaviour is identical.

Test Plan:
- Sequential: mode 0, wr_mode 1, base 6'h3E, count 4, ready=1 -> addrs 3E,3F,00,01, all cmd_wr=1. Done pulses the cycle after the 4th transfer; txn_cnt=4.
- Stride with backpressure: mode 1, stride 5, base 0, count 3, ready low for 3 cycles on the 2nd command -> addrs 00,05,0A. Addr 05 holds stable during the stall.
- LFSR: mode 2, wr_mode 3, count 8 -> addr/wr sequence matches a reference model seeded 16'hACE1. Restarting reproduces the identical sequence.
- Alternate + fixed: mode 3, wr_mode 2, base 2A, count 5 -> addr 2A always, wr 1,0,1,0,1.
- count=0 -> cmd_valid never rises, done pulses one cycle after start. Abort after 2 of 10 transfers -> txn_cnt=2, cmd_valid drops next cycle, done pulses.
- Reset asserted mid-burst at transfer 3 -> outputs zero immediately, no done. A subsequent start runs a full fresh burst. With ADDR_CMD_GEN_STATS_EN: wr_cnt+rd_cnt==txn_cnt on every cycle.
